// File: rtl/pkt_reflector.sv
// Packet reflector: buffers accepted stream packets in a FWFT FIFO, checks them against a
// rotating seed pattern, and counts good, bad, dropped and transmitted packets.
module pkt_reflector #(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    TUSER_WIDTH = 128,
   parameter int                    PKT_WORDS   = 16,
   parameter int                    FIFO_AW     = 5,
   parameter logic [DATA_WIDTH-1:0] SEED        = 64'hCAFEBEEFCAFEBEEF
) (
   input  logic                      axi_aclk,
   input  logic                      axi_aresetn,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
   input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   input  logic                      count_reset,
   output logic [31:0]               good_count,
   output logic [31:0]               err_count,
   output logic [31:0]               drop_count,
   output logic [31:0]               tx_count
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ENTRY_W    = DATA_WIDTH + STRB_WIDTH + TUSER_WIDTH + 1;
   localparam int DEPTH      = 1 << FIFO_AW;
   localparam int IDX_W      = $clog2(PKT_WORDS) + 1;
   localparam logic [FIFO_AW:0] DEPTH_OCC = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] PKT_OCC   = (FIFO_AW+1)'(PKT_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_WORDS - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_STORE = 2'd1;
   localparam logic [1:0] RX_DROP  = 2'd2;
   localparam logic [1:0] RX_TRUNC = 2'd3;

   function automatic logic [DATA_WIDTH-1:0] ror1(input logic [DATA_WIDTH-1:0] w);
      return {w[0], w[DATA_WIDTH-1:1]};
   endfunction

   logic [ENTRY_W-1:0]    mem [DEPTH];
   logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
   logic [FIFO_AW:0]      occ;
   logic [1:0]            state;
   logic [IDX_W-1:0]      beat_idx;
   logic [DATA_WIDTH-1:0] exp_word;
   logic                  bad;
   logic                  verdict_vld, verdict_good;

   logic                  has_room, push, pop, at_limit, cur_bad, drop_evt;
   logic [IDX_W-1:0]      cur_idx;
   logic [DATA_WIDTH-1:0] cur_exp;

   assign s_axis_tready = 1'b1;
   assign m_axis_tvalid = (occ != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = mem[rd_ptr];

   // In RX_IDLE the incoming beat is a first beat, so index and expected word restart here.
   always_comb begin
      has_room = (DEPTH_OCC - occ) >= PKT_OCC;
      push     = s_axis_tvalid && ((state == RX_IDLE && has_room) || state == RX_STORE);
      cur_idx  = (state == RX_IDLE) ? '0 : beat_idx;
      cur_exp  = (state == RX_IDLE) ? SEED : exp_word;
      at_limit = (cur_idx == LAST_IDX);
      cur_bad  = (state == RX_STORE && bad) || (s_axis_tdata != cur_exp);
      drop_evt = s_axis_tvalid && s_axis_tlast &&
                 ((state == RX_IDLE && !has_room) || state == RX_DROP);
   end

   always_ff @(posedge axi_aclk) begin
      if (push)
         mem[wr_ptr] <= {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast || at_limit};
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state        <= RX_IDLE;
         beat_idx     <= '0;
         exp_word     <= SEED;
         bad          <= 1'b0;
         verdict_vld  <= 1'b0;
         verdict_good <= 1'b0;
      end else begin
         verdict_vld  <= push && (s_axis_tlast || at_limit);
         verdict_good <= !cur_bad && s_axis_tlast && at_limit;
         if (push) begin
            beat_idx <= cur_idx + IDX_W'(1);
            exp_word <= ror1(cur_exp);
            bad      <= cur_bad;
            if (s_axis_tlast)  state <= RX_IDLE;
            else if (at_limit) state <= RX_TRUNC;
            else               state <= RX_STORE;
         end else if (s_axis_tvalid) begin
            if (state == RX_IDLE) state <= s_axis_tlast ? RX_IDLE : RX_DROP;
            else if (s_axis_tlast) state <= RX_IDLE;
         end
      end
   end

   // A clear wins over any increment landing on the same edge.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         good_count <= '0;
         err_count  <= '0;
         drop_count <= '0;
         tx_count   <= '0;
      end else if (count_reset) begin
         good_count <= '0;
         err_count  <= '0;
         drop_count <= '0;
         tx_count   <= '0;
      end else begin
         if (verdict_vld && verdict_good)  good_count <= good_count + 32'd1;
         if (verdict_vld && !verdict_good) err_count  <= err_count + 32'd1;
         if (drop_evt)                     drop_count <= drop_count + 32'd1;
         if (pop && m_axis_tlast)          tx_count   <= tx_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_pkt_reflector.sv
// Randomized self-checking bench for pkt_reflector with a packet-level reference model.
module tb_pkt_reflector;

   localparam int DW = 64, UW = 128, SW = 8, PKT = 16, DEPTH = 32;
   localparam logic [63:0] SEED = 64'hCAFEBEEFCAFEBEEF;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [SW-1:0] s_tstrb = '0;
   logic [UW-1:0] s_tuser = '0;
   logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [DW-1:0] m_tdata;
   logic [SW-1:0] m_tstrb;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid, m_tlast;
   logic          m_tready = 1'b0;
   logic          count_reset = 1'b0;
   logic [31:0]   good_count, err_count, drop_count, tx_count;

   always #5 clk = ~clk;

   pkt_reflector #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .PKT_WORDS(PKT), .FIFO_AW(5), .SEED(SEED)) dut (
      .axi_aclk(clk), .axi_aresetn(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .count_reset(count_reset),
      .good_count(good_count), .err_count(err_count), .drop_count(drop_count), .tx_count(tx_count)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   beat_t         exp_q[$];
   logic [63:0]   pkt_words[$];
   int            checks = 0, errors = 0, cyc = 0, first_pop_cyc = -1;
   int unsigned   m_good = 0, m_err = 0, m_drop = 0, m_tx = 0;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Expected word of beat k: the seed rotated right k times.
   function automatic logic [63:0] ref_word(input int k);
      int r = k % 64;
      if (r == 0) return SEED;
      return (SEED >> r) | (SEED << (64 - r));
   endfunction

   function automatic logic pick_rdy(input int mode);
      if (mode == 2) return ($urandom_range(99) < 70);
      return (mode == 1);
   endfunction

   // One clock cycle: apply inputs at the falling edge, check the output beat that will be
   // accepted at the coming rising edge against the expected queue.
   task automatic drive_cycle(input logic v, input logic [63:0] d, input logic [7:0] s,
                              input logic [127:0] u, input logic l, input logic rdy,
                              input logic cr, output int occ_before);
      beat_t e;
      @(negedge clk);
      s_tvalid = v; s_tdata = d; s_tstrb = s; s_tuser = u; s_tlast = l;
      m_tready = rdy; count_reset = cr;
      occ_before = exp_q.size();
      checks++;
      if (m_tvalid !== (exp_q.size() != 0)) begin
         errors++;
         $display("FAIL tvalid cyc=%0d: got %b, want %b", cyc, m_tvalid, exp_q.size() != 0);
      end
      if (m_tvalid === 1'b1 && rdy && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({m_tdata, m_tstrb, m_tuser, m_tlast} !== {e.d, e.s, e.u, e.l}) begin
            errors++;
            $display("FAIL out_beat cyc=%0d: got d=%h s=%h u=%h l=%b, want d=%h s=%h u=%h l=%b",
                     cyc, m_tdata, m_tstrb, m_tuser, m_tlast, e.d, e.s, e.u, e.l);
         end
         if (e.l) m_tx++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (cr) begin m_good = 0; m_err = 0; m_drop = 0; m_tx = 0; end
      cyc++;
   endtask

   task automatic idle(input int n, input int rdy_mode, input logic cr);
      int occ;
      for (int i = 0; i < n; i++)
         drive_cycle(1'b0, {$urandom, $urandom}, 8'($urandom), {4{$urandom}}, 1'b0,
                     pick_rdy(rdy_mode), cr, occ);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1, 1, 1'b0);
      idle(3, 1, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats still expected, want 0", exp_q.size());
      end
   endtask

   // Sends pkt_words; the model decides store/drop from occupancy at the first beat and
   // derives the verdict from length and pattern alone.
   task automatic send_packet(input int gap_pct, input int rdy_mode, input bit end_pkt);
      int          n = pkt_words.size();
      int          occ;
      bit          store = 0, good;
      logic [7:0]  s;
      logic [127:0] u;
      good = (n == PKT);
      for (int k = 0; k < n && k < PKT; k++)
         if (pkt_words[k] !== ref_word(k)) good = 0;
      for (int k = 0; k < n; k++) begin
         while ($urandom_range(99) < gap_pct) idle(1, rdy_mode, 1'b0);
         s = 8'($urandom);
         u = {$urandom, $urandom, $urandom, $urandom};
         drive_cycle(1'b1, pkt_words[k], s, u, end_pkt && (k == n - 1), pick_rdy(rdy_mode), 1'b0, occ);
         if (k == 0) store = (DEPTH - occ) >= PKT;
         if (store && k < PKT)
            exp_q.push_back('{pkt_words[k], s, u, (end_pkt && k == n - 1) || (k == PKT - 1)});
      end
      if (end_pkt) begin
         if (!store)    m_drop++;
         else if (good) m_good++;
         else           m_err++;
      end
   endtask

   task automatic build_packet(input int n, input int flip_beat, input int flip_bit);
      logic [63:0] w;
      pkt_words.delete();
      for (int k = 0; k < n; k++) begin
         w = ref_word(k);
         if (k == flip_beat) w[flip_bit] = ~w[flip_bit];
         pkt_words.push_back(w);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 3;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, want 0", m_tvalid); end
      if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b, want 1", s_tready); end
      if ({good_count, err_count, drop_count, tx_count} !== 128'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d %0d %0d %0d, want 0 0 0 0", good_count, err_count, drop_count, tx_count);
      end
      rstn = 1'b1;
   endtask

   task automatic test_good();
      int c0;
      idle(1, 1, 1'b1);
      build_packet(16, -1, 0);
      first_pop_cyc = -1;
      c0 = cyc;
      send_packet(0, 1, 1'b1);
      idle(1, 1, 1'b0);
      checks++;
      if (good_count !== 32'd0) begin errors++; $display("FAIL good_early: got %0d, want 0", good_count); end
      idle(1, 1, 1'b0);
      checks++;
      if (good_count !== 32'd1) begin errors++; $display("FAIL good_timing: got %0d, want 1", good_count); end
      drain();
      checks += 3;
      if (first_pop_cyc != c0 + 1) begin errors++; $display("FAIL good_latency: got cycle %0d, want %0d", first_pop_cyc, c0 + 1); end
      if (tx_count !== 32'd1) begin errors++; $display("FAIL good_tx: got %0d, want 1", tx_count); end
      if (err_count !== 32'd0) begin errors++; $display("FAIL good_err: got %0d, want 0", err_count); end
   endtask

   task automatic test_bad_data();
      idle(1, 1, 1'b1);
      build_packet(16, 7, 0);
      send_packet(0, 1, 1'b1);
      drain();
      checks += 3;
      if (err_count !== 32'd1) begin errors++; $display("FAIL bad_err: got %0d, want 1", err_count); end
      if (good_count !== 32'd0) begin errors++; $display("FAIL bad_good: got %0d, want 0", good_count); end
      if (tx_count !== 32'd1) begin errors++; $display("FAIL bad_tx: got %0d, want 1", tx_count); end
   endtask

   task automatic test_overflow();
      idle(1, 0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         build_packet(16, -1, 0);
         send_packet(0, 0, 1'b1);
      end
      idle(2, 0, 1'b0);
      checks += 2;
      if (drop_count !== 32'd1) begin errors++; $display("FAIL ovf_drop: got %0d, want 1", drop_count); end
      if (exp_q.size() != 32) begin errors++; $display("FAIL ovf_stored: got %0d, want 32", exp_q.size()); end
      drain();
      checks += 2;
      if (tx_count !== 32'd2) begin errors++; $display("FAIL ovf_tx: got %0d, want 2", tx_count); end
      if (good_count !== 32'd2) begin errors++; $display("FAIL ovf_good: got %0d, want 2", good_count); end
   endtask

   task automatic test_truncate();
      idle(1, 1, 1'b1);
      build_packet(20, -1, 0);
      send_packet(0, 1, 1'b1);
      drain();
      checks += 3;
      if (err_count !== 32'd1) begin errors++; $display("FAIL trunc_err: got %0d, want 1", err_count); end
      if (good_count !== 32'd0) begin errors++; $display("FAIL trunc_good: got %0d, want 0", good_count); end
      if (tx_count !== 32'd1) begin errors++; $display("FAIL trunc_tx: got %0d, want 1", tx_count); end
      build_packet(4, -1, 0);
      send_packet(0, 1, 1'b1);
      drain();
      checks += 2;
      if (err_count !== 32'd2) begin errors++; $display("FAIL short_err: got %0d, want 2", err_count); end
      if (tx_count !== 32'd2) begin errors++; $display("FAIL short_tx: got %0d, want 2", tx_count); end
   endtask

   task automatic test_count_reset();
      idle(1, 1, 1'b1);
      build_packet(16, -1, 0);
      send_packet(0, 1, 1'b1);
      idle(1, 1, 1'b1);
      drain();
      checks++;
      if ({good_count, err_count, drop_count, tx_count} !== 128'd0) begin
         errors++;
         $display("FAIL count_reset: got %0d %0d %0d %0d, want 0 0 0 0", good_count, err_count, drop_count, tx_count);
      end
   endtask

   task automatic test_async_reset();
      idle(1, 1, 1'b1);
      build_packet(8, -1, 0);
      send_packet(0, 0, 1'b0);
      idle(1, 0, 1'b0);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL areset_tvalid: got %b, want 0", m_tvalid); end
      exp_q.delete();
      m_good = 0; m_err = 0; m_drop = 0; m_tx = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      build_packet(16, -1, 0);
      send_packet(0, 1, 1'b1);
      drain();
      checks += 3;
      if (good_count !== 32'd1) begin errors++; $display("FAIL areset_good: got %0d, want 1", good_count); end
      if (err_count !== 32'd0) begin errors++; $display("FAIL areset_err: got %0d, want 0", err_count); end
      if (tx_count !== 32'd1) begin errors++; $display("FAIL areset_tx: got %0d, want 1", tx_count); end
   endtask

   task automatic test_random();
      int n;
      idle(1, 1, 1'b1);
      for (int p = 0; p < 40; p++) begin
         n = ($urandom_range(9) < 6) ? PKT : $urandom_range(1, 20);
         if ($urandom_range(3) == 0) build_packet(n, $urandom_range(0, n - 1), $urandom_range(0, 63));
         else                        build_packet(n, -1, 0);
         send_packet(20, 2, 1'b1);
         idle($urandom_range(0, 3), 2, 1'b0);
      end
      drain();
      checks += 4;
      if (good_count !== m_good) begin errors++; $display("FAIL rand_good: got %0d, want %0d", good_count, m_good); end
      if (err_count !== m_err) begin errors++; $display("FAIL rand_err: got %0d, want %0d", err_count, m_err); end
      if (drop_count !== m_drop) begin errors++; $display("FAIL rand_drop: got %0d, want %0d", drop_count, m_drop); end
      if (tx_count !== m_tx) begin errors++; $display("FAIL rand_tx: got %0d, want %0d", tx_count, m_tx); end
   endtask

   initial begin
      test_reset();
      test_good();
      test_bad_data();
      test_overflow();
      test_truncate();
      test_count_reset();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
